// File: rtl/bus_arbiter_pkg.sv
// Shared types and address map for the fetch/data bus arbiter.
package bus_arbiter_pkg;

  // Address map: inclusive base/limit pairs
  localparam logic [31:0] IMEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_3FFF;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_4000;
  localparam logic [31:0] DMEM_LIMIT = 32'h0000_6FFF;
  localparam logic [31:0] UART_BASE  = 32'h0000_8000;
  localparam logic [31:0] UART_LIMIT = 32'h0000_800F;
  localparam logic [31:0] GPIO_BASE  = 32'h0000_8010;
  localparam logic [31:0] GPIO_LIMIT = 32'h0000_801F;
  localparam logic [31:0] TIMER_BASE  = 32'h0000_8020;
  localparam logic [31:0] TIMER_LIMIT = 32'h0000_802F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } arb_state_e;

  typedef enum logic [2:0] {
    RGN_NONE  = 3'd0,
    RGN_IMEM  = 3'd1,
    RGN_DMEM  = 3'd2,
    RGN_UART  = 3'd3,
    RGN_GPIO  = 3'd4,
    RGN_TIMER = 3'd5
  } region_e;

  // Offset-from-base compare: an address below base wraps to a huge offset,
  // so one unsigned compare covers both bounds without a constant ">= 0".
  function automatic logic addr_in_region(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] limit);
    return (addr - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/bus_arbiter_region_decoder.sv
// Address region lookup and access-legality check for the granted request.
module region_decoder
  import bus_arbiter_pkg::*;
(
  input  logic [31:0] i_addr,
  input  logic        i_fetch,
  input  logic        i_we,
  output logic        o_fault
);

  region_e w_region;

  // Map the address onto a region; regions never overlap so order is free
  always_comb begin
    w_region = RGN_NONE;
    if (addr_in_region(i_addr, IMEM_BASE, IMEM_LIMIT)) begin
      w_region = RGN_IMEM;
    end else if (addr_in_region(i_addr, DMEM_BASE, DMEM_LIMIT)) begin
      w_region = RGN_DMEM;
    end else if (addr_in_region(i_addr, UART_BASE, UART_LIMIT)) begin
      w_region = RGN_UART;
    end else if (addr_in_region(i_addr, GPIO_BASE, GPIO_LIMIT)) begin
      w_region = RGN_GPIO;
    end else if (addr_in_region(i_addr, TIMER_BASE, TIMER_LIMIT)) begin
      w_region = RGN_TIMER;
    end
  end

  // Flag unmapped addresses, fetches outside imem and data writes into imem
  always_comb begin
    o_fault = 1'b0;
    if (w_region == RGN_NONE) begin
      o_fault = 1'b1;
    end else if (i_fetch && (w_region != RGN_IMEM)) begin
      o_fault = 1'b1;
    end else if (!i_fetch && i_we && (w_region == RGN_IMEM)) begin
      o_fault = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) to single-bus arbiter, one transaction in flight.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | pick a winner, pulse its gnt, latch its request
// ACCESS | drive bus_valid until bus_ready or the wait timer expires
// RESP   | one-cycle rvalid to the owner, rdata already captured
// ERR    | one-cycle err to the owner (decode fault or bus timeout)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // bus port
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  // Wait timer counts down from TIMEOUT_CYCLES-1; terminal count is zero
  localparam int LP_WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LP_WAIT_W-1:0] LP_WAIT_LOAD = LP_WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam int LP_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LP_STARVE_W-1:0] LP_STARVE_MAX = LP_STARVE_W'(STARVE_LIMIT);

  arb_state_e r_state;
  arb_state_e w_next_state;

  logic                   r_owner_if;
  logic [31:0]            r_addr;
  logic                   r_we;
  logic [3:0]             r_wstrb;
  logic [31:0]            r_wdata;
  logic [LP_WAIT_W-1:0]   r_wait;
  logic [LP_STARVE_W-1:0] r_starve_cnt;
  logic [31:0]            r_if_rdata;
  logic [31:0]            r_d_rdata;

  logic        w_starved;
  logic        w_pick_if;
  logic        w_pick_d;
  logic        w_grant;
  logic [31:0] w_sel_addr;
  logic        w_sel_we;
  logic        w_fault;
  logic        w_timeout;

  // Arbitration: data first, unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    w_starved  = if_req && (r_starve_cnt == LP_STARVE_MAX);
    w_pick_if  = if_req && (!d_req || w_starved);
    w_pick_d   = d_req && !w_starved;
    w_grant    = (r_state == ST_IDLE) && (w_pick_if || w_pick_d);
    w_sel_addr = w_pick_if ? if_addr : d_addr;
    w_sel_we   = w_pick_d && d_we;
    w_timeout  = (r_wait == '0) && !bus_ready;
  end

  region_decoder u_region_decoder (
    .i_addr  (w_sel_addr),
    .i_fetch (w_pick_if),
    .i_we    (w_sel_we),
    .o_fault (w_fault)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_if || w_pick_d) begin
          w_next_state = w_fault ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus_ready) begin
          w_next_state = ST_RESP;
        end else if (w_timeout) begin
          w_next_state = ST_ERR;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Per-state handshake outputs; grants are combinational and masked while in reset
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_err    = 1'b0;
    d_err     = 1'b0;
    bus_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if_gnt = !rst && w_pick_if;
        d_gnt  = !rst && w_pick_d;
      end
      ST_ACCESS: bus_valid = 1'b1;
      ST_RESP: begin
        if_rvalid = r_owner_if;
        d_rvalid  = !r_owner_if;
      end
      ST_ERR: begin
        if_err = r_owner_if;
        d_err  = !r_owner_if;
      end
      default: ;
    endcase
  end

  assign bus_addr  = r_addr;
  assign bus_we    = r_we;
  assign bus_wstrb = r_wstrb;
  assign bus_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  // Latch the winner's request so the bus sees stable signals through ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_if <= 1'b0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_owner_if <= w_pick_if;
      r_addr     <= w_sel_addr;
      r_we       <= w_sel_we;
      r_wstrb    <= w_pick_if ? 4'h0 : d_wstrb;
      r_wdata    <= w_pick_if ? 32'h0 : d_wdata;
    end
  end

  // Bus wait timer: loaded on grant, counts idle ACCESS cycles down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (w_grant) begin
      r_wait <= LP_WAIT_LOAD;
    end else if ((r_state == ST_ACCESS) && !bus_ready && (r_wait != '0)) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  // Starvation counter: data grants while fetch waits, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_req) begin
      r_starve_cnt <= '0;
    end else if (w_grant && w_pick_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant && w_pick_d && (r_starve_cnt != LP_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Capture read data on completion; writes report zero, other cycles hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if ((r_state == ST_ACCESS) && bus_ready) begin
      if (r_owner_if) begin
        r_if_rdata <= r_we ? 32'h0 : bus_rdata;
      end else begin
        r_d_rdata  <= r_we ? 32'h0 : bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-timeline reference model plus directed cases.
module tb_bus_arbiter;

  localparam int TMO = 16;
  localparam int STV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus controls for the bus slave and the model
  int          cfg_lat = 1;        // >0 ready after that many valid cycles, 0 never, <0 random
  bit          cfg_rdata_en = 1'b0;
  logic [31:0] cfg_rdata = '0;
  bit          seen_if_gnt = 1'b0;
  bit          seen_d_gnt = 1'b0;

  // reference model: timeline of the single outstanding transaction
  int          m_free = 0;
  int          m_vf = 1, m_vt = 0;
  int          m_ready = -1;
  int          m_resp = -1;
  bit          m_err = 1'b0;
  bit          m_fetch = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_wstrb = '0;
  int          m_starve = 0;
  logic [31:0] m_if_rdata = '0, m_d_rdata = '0;

  bus_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Legality straight from the address map
  function automatic bit legal(input logic [31:0] a, input bit fetch, input bit we);
    bit imem, mapped;
    imem   = (a <= 32'h3FFF);
    mapped = imem || (a >= 32'h4000 && a <= 32'h6FFF) || (a >= 32'h8000 && a <= 32'h802F);
    return mapped && !(fetch && !imem) && !(!fetch && we && imem);
  endfunction

  function automatic logic [31:0] pick_addr(input bit fetch);
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 23);
    if (r >= 16) begin
      a = fetch ? 32'($urandom_range(0, 32'h3FFF)) : 32'($urandom_range(0, 32'h8040));
      a[1:0] = 2'b00;
    end else begin
      case (r)
        0:  a = 32'h0000_0000;  1:  a = 32'h0000_0100;
        2:  a = 32'h0000_3FFC;  3:  a = 32'h0000_3FFF;
        4:  a = 32'h0000_4000;  5:  a = 32'h0000_6FFC;
        6:  a = 32'h0000_6FFF;  7:  a = 32'h0000_7000;
        8:  a = 32'h0000_7FFC;  9:  a = 32'h0000_8000;
        10: a = 32'h0000_800F;  11: a = 32'h0000_8010;
        12: a = 32'h0000_8024;  13: a = 32'h0000_802F;
        14: a = 32'h0000_8030;  default: a = 32'hFFFF_FFF0;
      endcase
    end
    return a;
  endfunction

  // Bus slave: ready exactly when the model schedules it, random noise outside valid windows
  always @(posedge clk) begin
    #1;
    bus_rdata = cfg_rdata_en ? cfg_rdata : $urandom;
    if (cyc == m_ready) bus_ready = 1'b1;
    else if (cyc >= m_vf && cyc <= m_vt) bus_ready = 1'b0;
    else bus_ready = 1'($urandom_range(0, 1));
  end

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin : p_cmp
    bit e_ig, e_dg, e_val, bad;
    int lat, r;
    seen_if_gnt = if_gnt;
    seen_d_gnt  = d_gnt;
    if (rst) begin
      chk("reset_outputs_zero",
          32'(|{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata}), 32'd0);
      m_free = cyc + 1; m_vf = 1; m_vt = 0; m_ready = -1; m_resp = -1;
      m_starve = 0; m_if_rdata = '0; m_d_rdata = '0;
    end else begin
      e_ig = 1'b0; e_dg = 1'b0;
      if (cyc >= m_free) begin
        if (if_req && (!d_req || m_starve == STV)) e_ig = 1'b1;
        else if (d_req) e_dg = 1'b1;
      end
      chk("if_gnt", 32'(if_gnt), 32'(e_ig));
      chk("d_gnt", 32'(d_gnt), 32'(e_dg));
      e_val = (cyc >= m_vf) && (cyc <= m_vt);
      chk("bus_valid", 32'(bus_valid), 32'(e_val));
      if (e_val) begin
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_we", 32'(bus_we), 32'(m_we));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(m_wstrb));
        chk("bus_wdata", bus_wdata, m_wdata);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(cyc == m_resp && m_fetch && !m_err));
      chk("d_rvalid", 32'(d_rvalid), 32'(cyc == m_resp && !m_fetch && !m_err));
      chk("if_err", 32'(if_err), 32'(cyc == m_resp && m_fetch && m_err));
      chk("d_err", 32'(d_err), 32'(cyc == m_resp && !m_fetch && m_err));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);

      if (cyc == m_ready) begin
        if (m_fetch) m_if_rdata = bus_rdata;
        else m_d_rdata = m_we ? 32'h0 : bus_rdata;
      end

      if (!if_req) m_starve = 0;
      else if (e_ig) m_starve = 0;
      else if (e_dg && m_starve < STV) m_starve++;

      if (e_ig || e_dg) begin
        m_fetch = e_ig;
        m_addr  = e_ig ? if_addr : d_addr;
        m_we    = e_dg && d_we;
        m_wstrb = e_ig ? 4'h0 : d_wstrb;
        m_wdata = e_ig ? 32'h0 : d_wdata;
        if (cfg_lat > 0) lat = cfg_lat;
        else if (cfg_lat == 0) lat = TMO + 1;
        else begin
          r = int'($urandom_range(0, 9));
          if (r < 7) lat = int'($urandom_range(1, 3));
          else if (r < 9) lat = int'($urandom_range(TMO - 1, TMO));
          else lat = TMO + 1;
        end
        bad = !legal(m_addr, m_fetch, m_we);
        if (bad) begin
          m_vf = cyc + 1; m_vt = cyc; m_ready = -1;
          m_resp = cyc + 1; m_err = 1'b1; m_free = cyc + 2;
        end else if (lat <= TMO) begin
          m_vf = cyc + 1; m_vt = cyc + lat; m_ready = cyc + lat;
          m_resp = cyc + lat + 1; m_err = 1'b0; m_free = cyc + lat + 2;
        end else begin
          m_vf = cyc + 1; m_vt = cyc + TMO; m_ready = -1;
          m_resp = cyc + TMO + 1; m_err = 1'b1; m_free = cyc + TMO + 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  initial begin : p_stim
    int gcount, vc, resp;
    logic [9:0] seq;

    // reset: a pending fetch must not be granted while rst is high
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    tick();
    rst = 1'b0; if_req = 1'b0;
    idle(2);

    // fetch read at 0x100, ready one cycle after grant
    cfg_lat = 1; cfg_rdata_en = 1'b1; cfg_rdata = 32'hDEADBEEF;
    tick(); if_req = 1'b1; if_addr = 32'h100; d_req = 1'b0;
    @(negedge clk); chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    tick(); if_req = 1'b0;
    @(negedge clk); chk("t1_bus_valid", 32'(bus_valid), 32'd1);
    chk("t1_bus_addr", bus_addr, 32'h100);
    tick();
    @(negedge clk); chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    idle(3);

    // both ports requesting continuously
    cfg_rdata_en = 1'b0;
    tick(); if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h4000; d_we = 1'b0;
    gcount = 0; seq = '0;
    for (int k = 0; k < 60 && gcount < 10; k++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        seq[gcount] = if_gnt;
        gcount++;
      end
    end
    chk("t2_grant_count", 32'(gcount), 32'd10);
    chk("t2_grant_seq", 32'(seq), 32'h210);
    idle(4);

    // data read of an unmapped hole
    tick(); d_req = 1'b1; d_addr = 32'h7000; d_we = 1'b0;
    @(negedge clk); chk("t3_d_gnt", 32'(d_gnt), 32'd1);
    chk("t3_bus_valid0", 32'(bus_valid), 32'd0);
    tick(); d_req = 1'b0;
    @(negedge clk); chk("t3_d_err", 32'(d_err), 32'd1);
    chk("t3_bus_valid1", 32'(bus_valid), 32'd0);
    idle(2);

    // data write into imem, then fetch from dmem
    tick(); d_req = 1'b1; d_addr = 32'h10; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h1234;
    @(negedge clk); chk("t4_d_gnt", 32'(d_gnt), 32'd1);
    tick(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); chk("t4_d_err", 32'(d_err), 32'd1);
    tick(); if_req = 1'b1; if_addr = 32'h4000;
    @(negedge clk); chk("t4_if_gnt", 32'(if_gnt), 32'd1);
    tick(); if_req = 1'b0;
    @(negedge clk); chk("t4_if_err", 32'(if_err), 32'd1);
    idle(2);

    // uart read with no bus_ready: timeout
    cfg_lat = 0;
    tick(); d_req = 1'b1; d_addr = 32'h8004; d_we = 1'b0;
    @(negedge clk); chk("t5_d_gnt", 32'(d_gnt), 32'd1);
    vc = 0;
    for (int k = 1; k <= TMO + 1; k++) begin
      tick(); d_req = 1'b0;
      @(negedge clk);
      vc += int'(bus_valid);
      if (k == TMO + 1) begin
        chk("t5_d_err", 32'(d_err), 32'd1);
        chk("t5_bus_valid_off", 32'(bus_valid), 32'd0);
      end
    end
    chk("t5_valid_cycles", 32'(vc), 32'(TMO));
    idle(2);

    // reset during ACCESS, then a normal transaction
    tick(); d_req = 1'b1; d_addr = 32'h4004; d_we = 1'b0;
    @(negedge clk); chk("t6_d_gnt", 32'(d_gnt), 32'd1);
    tick(); d_req = 1'b0;
    @(negedge clk); chk("t6_bus_valid", 32'(bus_valid), 32'd1);
    tick(); rst = 1'b1;
    @(negedge clk); chk("t6_valid_dropped", 32'(bus_valid), 32'd0);
    tick(); rst = 1'b0;
    resp = 0;
    for (int k = 0; k < TMO + 4; k++) begin
      @(negedge clk);
      resp += int'(d_rvalid || d_err || if_rvalid || if_err);
      tick();
    end
    chk("t6_no_response", 32'(resp), 32'd0);
    cfg_lat = 2; cfg_rdata_en = 1'b1; cfg_rdata = 32'h1234_5678;
    d_req = 1'b1; d_addr = 32'h4008; d_we = 1'b0;
    @(negedge clk); chk("t6_new_gnt", 32'(d_gnt), 32'd1);
    tick(); d_req = 1'b0;
    tick(); tick();
    @(negedge clk); chk("t6_new_rvalid", 32'(d_rvalid), 32'd1);
    chk("t6_new_rdata", d_rdata, 32'h1234_5678);
    idle(3);

    // randomized traffic with occasional resets
    cfg_lat = -1; cfg_rdata_en = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      if (!if_req || seen_if_gnt) begin
        if_req  = ($urandom_range(0, 99) < 50);
        if_addr = pick_addr(1'b1);
      end
      if (!d_req || seen_d_gnt) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_addr  = pick_addr(1'b0);
        d_we    = 1'($urandom_range(0, 1));
        d_wstrb = 4'($urandom);
        d_wdata = $urandom;
      end
    end
    idle(TMO + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles bus_valid is held without bus_ready before an error is returned.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch request is pending.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide the fetch port:
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  32  fetch address.
- if_gnt  output  1  one-cycle request-accepted pulse.
- if_rvalid  output  1  one-cycle read-data-valid pulse.
- if_rdata  output  32  read data.
- if_err  output  1  one-cycle error-response pulse.
REQ-005 SHALL provide the data port:
- d_req  input  1  data request.
- d_addr  input  32  data address.
- d_we  input  1  write enable.
- d_wstrb  input  4  byte strobes.
- d_wdata  input  32  write data.
- d_gnt  output  1  one-cycle accept pulse.
- d_rvalid  output  1  one-cycle response pulse, for reads and writes.
- d_rdata  output  32  read data.
- d_err  output  1  one-cycle error pulse.
REQ-006 SHALL provide the bus port:
- bus_valid  output  1  transaction valid.
- bus_addr  output  32  transaction address.
- bus_we  output  1  write enable.
- bus_wstrb  output  4  byte strobes.
- bus_wdata  output  32  write data.
- bus_rdata  input  32  read data.
- bus_ready  input  1  transaction complete.

Function
REQ-007 SHALL use FSM states IDLE, ACCESS, RESP and ERR, with one transaction outstanding at a time.
REQ-008 In IDLE, SHALL pick a winner combinationally, assert its gnt in the same cycle, register the winner's addr/we/wstrb/wdata, and move to ACCESS, or to ERR on a decode fault.
REQ-009 Arbitration SHALL give data priority over fetch, except that fetch SHALL win when if_req=1 and starve_cnt==STARVE_LIMIT.
REQ-010 starve_cnt SHALL increment on each data grant with if_req=1, clear on a fetch grant or when if_req=0, and saturate at STARVE_LIMIT.
REQ-011 A decode fault SHALL be any of the following:
- address outside every mapped region (imem 0x0000_0000-0x0000_3FFF, dmem 0x0000_4000-0x0000_6FFF, uart 0x0000_8000-0x0000_800F, gpio 0x0000_8010-0x0000_801F, timer 0x0000_8020-0x0000_802F);
- fetch outside imem;
- data write to imem.
REQ-012 ERR SHALL pulse the granted port's err for one cycle, never assert bus_valid, and return to IDLE.
REQ-013 ACCESS SHALL hold bus_valid=1 with stable registered signals until bus_ready=1, then capture bus_rdata and move to RESP.
REQ-014 RESP SHALL pulse the granted port's rvalid for one cycle with rdata valid, then return to IDLE.
REQ-015 rdata SHALL hold its last value otherwise, and SHALL be 0 for write responses.
REQ-016 The ACCESS wait counter SHALL reach TIMEOUT_CYCLES with bus_ready=0 and then force bus_valid=0, pulse err next cycle, and return to IDLE.
REQ-017 bus_ready SHALL be ignored outside ACCESS.
REQ-018 Minimum latency SHALL be: req/gnt at cycle N, bus_valid at N+1, rvalid at N+2 if bus_ready arrives at N+1; throughput SHALL be one transaction per 3 cycles.
REQ-019 Only one of if_gnt/d_gnt SHALL be asserted in any cycle, and no gnt SHALL be asserted outside IDLE.

Reset
REQ-020 rst SHALL immediately force state IDLE, starve_cnt=0, wait counter=0, all outputs 0 and registered rdata 0.
REQ-021 An in-flight transaction SHALL be discarded without any response.

Structure
REQ-022 A shared package SHALL hold the region base/limit constants and the state enum.
REQ-023 Region decoding SHALL be a sub-module named region_decoder.

Verification
REQ-024 The bench SHALL cover:
- Fetch read at 0x100, bus_ready at cycle 1, bus_rdata=0xDEADBEEF -> if_gnt at cycle 0, if_rvalid at cycle 2 with 0xDEADBEEF.
- Both ports requesting continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Data read at 0x7000 -> d_err pulse at cycle 1, bus_valid never set.
- Data write to 0x0000_0010 -> d_err pulse; fetch at 0x4000 -> if_err pulse.
- Data read at 0x8004 with bus_ready never asserted -> bus_valid held 16 cycles, then d_err pulse.
- rst asserted in ACCESS -> bus_valid low the same cycle, no response, next request served normally.
